imem_loader: RTL
================

# imem_loader

Runtime instruction-memory writer for the single-cycle MIPS CPU. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive word addresses of instruction memory. It holds the CPU stalled until a complete, valid image is written, so the CPU can fetch a program loaded at run time instead of one preloaded from a file.

## Interface
- `ADDR_WIDTH`, 10: instruction memory word-address width; capacity is 2**ADDR_WIDTH words.
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: byte-stream valid.
- `in_data`  in  8: byte-stream data.
- `in_ready`  out  1: byte-stream ready.
- `im_we`  out  1: instruction-memory write strobe, one cycle per word.
- `im_addr`  out  ADDR_WIDTH: word address.
- `im_wdata`  out  32: word to write.
- `cpu_hold`  out  1: stall request to the CPU; the PC must not advance while it is high.
- `done`  out  1: image loaded successfully.
- `error`  out  1: frame rejected.

## Operation
- Frame format: sync byte `8'hA5`, then LEN_HI, then LEN_LO (word count N, 16-bit), then 4·N payload bytes (MSB first per word).
- A byte is accepted when `in_valid && in_ready` on a rising edge. `in_ready` is 1 in every state when not in reset.
- States:
  - IDLE: discard every byte except `A5`. On `A5`, go to LEN_HI.
  - LEN_HI: capture the byte, go to LEN_LO.
  - LEN_LO: capture the byte. If N == 0, go to DONE (or CSUM, if compiled in). If N > 2**ADDR_WIDTH, go to ERR. Otherwise go to DATA.
  - DATA: shift bytes into a 32-bit register. On the 4th byte, write the word at `word_cnt`, increment `word_cnt`, and clear the byte count. After the word-N write, go to DONE (or CSUM).
  - DONE and ERR: discard bytes except `A5`. On `A5`, clear `done`/`error`, assert `cpu_hold`, clear counters, and go to LEN_HI.
- `word_cnt` is ADDR_WIDTH+1 bits wide, so N = 2**ADDR_WIDTH writes addresses 0 through 2**ADDR_WIDTH−1 without aliasing.
- `im_addr` is the low ADDR_WIDTH bits of `word_cnt`.
- `cpu_hold` is 1 in every state except DONE. It stays 1 in ERR.
- Reset mid-frame returns the block to IDLE. Words already written stay in memory; the loader never clears memory.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0. `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0.
- All outputs are registered.
- `im_we`, `im_addr` and `im_wdata` are valid in the cycle after the 4th byte of a word is accepted. The write lasts exactly one cycle.
- `done` rises, and `cpu_hold` falls, one cycle after the final `im_we` pulse. The CPU therefore never fetches in the same cycle as a write.
- For N == 0, `done` rises in the cycle after LEN_LO is accepted.
- `error` rises in the cycle after the rejecting byte is accepted and holds until reset or a new `A5`.
- A byte arriving in the same cycle as `rst_n`=0 is dropped.
- Sustained throughput: 1 byte per cycle; no back-pressure.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - One extra byte follows the payload, in state CSUM.
  - It must equal the XOR of all payload bytes (8'h00 for N == 0).
  - Match: go to DONE. Mismatch: go to ERR, with `cpu_hold` staying 1. Words already written stay in memory.
- `IMEM_LOADER_CHECKSUM_EN` undefined: the CSUM state and the XOR accumulator are not built. DATA and N == 0 go directly to DONE.

## Structure
- Shared package/header `imem_loader_defs`:
  - state encoding localparams (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR);
  - `SYNC_BYTE` = 8'hA5.
- Single module, no sub-modules. The byte-to-word shifter is small enough to stay inline.
- Top-level integration: `cpu_hold` gates PC update; `im_*` drives the IM write port.

## Test plan
- Bytes `A5 00 02 24 08 00 05 21 09 00 01` (plus `00` if checksum enabled) -> `im_we` at addr 0 with `32'h24080005`, then addr 1 with `32'h21090001`. `done`=1 and `cpu_hold`=0 one cycle later.
- Bytes `00 FF 12` followed by the frame above -> leading bytes ignored, identical writes.
- `A5 00 00` -> no `im_we`; `done`=1 in the cycle after the last byte.
- `ADDR_WIDTH`=10, `A5 04 01` -> no writes, `error`=1, `cpu_hold`=1. A following valid frame clears `error` and loads normally.
- Checksum enabled, first frame with final byte `01` -> two writes occur, then `error`=1 and `cpu_hold`=1.
- `rst_n` pulled low after 6 payload bytes -> exactly one `im_we` seen before reset. After release: IDLE, `cpu_hold`=1, `done`=0. A full resend then completes.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_defs: shared state encoding and framing constants
// for the runtime instruction-memory loader.
package imem_loader_defs;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream -> big-endian words -> IM write port.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_defs::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    state_t              state;
    logic [15:0]         len;
    logic [ADDR_WIDTH:0] word_cnt;
    logic [1:0]          byte_cnt;
    logic [23:0]         shreg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    logic                accept;
    logic [ADDR_WIDTH:0] wc_inc;
    logic [15:0]         n_new;
    logic                last_word;
    logic                too_big;

    assign accept    = in_valid && in_ready;
    assign wc_inc    = word_cnt + (ADDR_WIDTH+1)'(1);
    assign n_new     = {len[15:8], in_data};
    assign last_word = (32'(wc_inc) == 32'(len));
    assign too_big   = (32'(n_new) > (32'd1 << ADDR_WIDTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            len      <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            in_ready <= 1'b1;
            im_we    <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        state    <= S_LEN_HI;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                        word_cnt <= '0;
                        byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end else if (state == S_DONE) begin
                        // release lags the last write by one cycle
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= in_data;
                        state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= in_data;
                        if (n_new == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state    <= S_CSUM;
`else
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else if (too_big) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ in_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            im_we    <= 1'b1;
                            im_addr  <= word_cnt[ADDR_WIDTH-1:0];
                            im_wdata <= {shreg, in_data};
                            word_cnt <= wc_inc;
                            byte_cnt <= 2'd0;
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state <= S_CSUM;
`else
                                state <= S_DONE;
`endif
                            end
                        end else begin
                            shreg    <= {shreg[15:0], in_data};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        if (in_data == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
